syndrome_gen: RTL

//  Error-injection / syndrome generator for the 5-qubit code: the transmit side feeding the codebase's

---
 rtl/qec5_pkg.sv | 51 +++++
 rtl/syndrome_gen_if.sv | 10 +
 rtl/qec_slot_seq.sv | 23 ++
 rtl/syndrome_gen.sv | 105 ++++++++++
 4 files changed

// File: rtl/qec5_pkg.sv
// Shared definitions for the 5-qubit code: axis encodings, the single-qubit
// Pauli syndrome table and its inverse (syndrome -> one-hot correction).
package qec5_pkg;

  localparam int NUM_QUBITS = 5;

  typedef enum logic [1:0] {
    AX_IDLE = 2'b00,
    AX_X    = 2'b01,
    AX_Y    = 2'b10,
    AX_Z    = 2'b11
  } axis_e;

  // Ancilla syndrome for a single Pauli error on one qubit (qubit 0 = correction MSB).
  function automatic logic [3:0] syndrome_of(input logic [1:0] axis, input logic [2:0] qubit);
    logic [3:0] s;
    s = 4'b0000;
    case ({axis, qubit})
      {AX_X, 3'd0}: s = 4'b0001;
      {AX_X, 3'd1}: s = 4'b1000;
      {AX_X, 3'd2}: s = 4'b1100;
      {AX_X, 3'd3}: s = 4'b0110;
      {AX_X, 3'd4}: s = 4'b0011;
      {AX_Y, 3'd0}: s = 4'b1011;
      {AX_Y, 3'd1}: s = 4'b1101;
      {AX_Y, 3'd2}: s = 4'b1110;
      {AX_Y, 3'd3}: s = 4'b1111;
      {AX_Y, 3'd4}: s = 4'b0111;
      {AX_Z, 3'd0}: s = 4'b1010;
      {AX_Z, 3'd1}: s = 4'b0101;
      {AX_Z, 3'd2}: s = 4'b0010;
      {AX_Z, 3'd3}: s = 4'b1001;
      {AX_Z, 3'd4}: s = 4'b0100;
      default:      s = 4'b0000;
    endcase
    return s;
  endfunction

  // Inverse table for checkers: one-hot correction for a syndrome seen in an axis slot.
  function automatic logic [4:0] correction_of(input logic [1:0] axis, input logic [3:0] syn);
    logic [4:0] c;
    logic [2:0] q;
    c = 5'b00000;
    for (int i = 0; i < NUM_QUBITS; i++) begin
      q = 3'(i);
      if (syn != 4'b0000 && syndrome_of(axis, q) == syn) c = 5'b10000 >> q;
    end
    return c;
  endfunction

endpackage

// File: rtl/syndrome_gen_if.sv
// Error-request handshake between an error source and the syndrome generator.
interface syndrome_gen_if;
  logic       err_valid;
  logic       err_ready;
  logic [2:0] err_qubit;
  logic [1:0] err_axis;

  modport master (output err_valid, output err_qubit, output err_axis, input err_ready);
  modport slave  (input err_valid, input err_qubit, input err_axis, output err_ready);
endinterface

// File: rtl/qec_slot_seq.sv
// Shared slot timeline: idle for one cycle after reset, then X -> Y -> Z forever.
module qec_slot_seq
  import qec5_pkg::*;
(
  input  logic  CLK,
  input  logic  RST_N,
  output axis_e slot
);

  // Advance the rotation every cycle; idle only leaves once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      slot <= AX_IDLE;
    end else begin
      case (slot)
        AX_X:    slot <= AX_Y;
        AX_Y:    slot <= AX_Z;
        default: slot <= AX_X;
      endcase
    end
  end

endmodule

// File: rtl/syndrome_gen.sv
// Syndrome generator: holds one single-qubit Pauli error until its axis slot
// comes round, then drives the matching ancilla syndrome for exactly one slot.
// Optional LFSR mode injects pseudo-random errors when no request is offered.
module syndrome_gen
  import qec5_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED  = 8'hA5,
  parameter int         OUT_STAGES = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  syndrome_gen_if.slave        req,
  input  logic                 rand_en,
  output logic [3:0]           ancilla,
  output logic [1:0]           anc_axis,
  output logic [7:0]           inj_count,
  output logic                 illegal
);

  localparam logic [2:0] MAX_QUBIT = 3'(NUM_QUBITS - 1);

  axis_e      slot;
  logic       pending;
  logic [2:0] pend_qubit;
  axis_e      pend_axis;
  logic [7:0] lfsr;
  logic       emit;
  logic       req_legal;
  logic [2:0] rnd_qubit;
  axis_e      rnd_axis;
  logic [3:0] anc_p0;
  logic [1:0] axis_p0;
  logic [5:0] tap [OUT_STAGES+1];

  // Galois form of x^8+x^6+x^5+x^4+1 (shift right, feed back through 0xB8).
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return (l >> 1) ^ (l[0] ? 8'hB8 : 8'h00);
  endfunction

  qec_slot_seq u_slot (
    .CLK  (CLK),
    .RST_N(RST_N),
    .slot (slot)
  );

  assign req.err_ready = !pending;
  assign emit          = pending && (pend_axis == slot);
  assign req_legal     = (req.err_qubit <= MAX_QUBIT) && (req.err_axis != AX_IDLE);
  assign rnd_qubit     = lfsr[2:0] % 3'd5;
  assign rnd_axis      = (lfsr[4:3] == 2'b00) ? AX_X : axis_e'(lfsr[4:3]);

  // Request slot: accept external or LFSR errors while empty, release on emission.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending    <= 1'b0;
      pend_qubit <= 3'd0;
      pend_axis  <= AX_IDLE;
      lfsr       <= LFSR_SEED;
      illegal    <= 1'b0;
    end else if (pending) begin
      if (emit) pending <= 1'b0;
    end else if (req.err_valid) begin
      if (req_legal) begin
        pending    <= 1'b1;
        pend_qubit <= req.err_qubit;
        pend_axis  <= axis_e'(req.err_axis);
      end else begin
        illegal <= 1'b1;
      end
    end else if (rand_en) begin
      pending    <= 1'b1;
      pend_qubit <= rnd_qubit;
      pend_axis  <= rnd_axis;
      lfsr       <= lfsr_step(lfsr);
    end
  end

  // Stage 0: syndrome for the matching slot, slot tag every cycle, emission count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      anc_p0    <= 4'b0000;
      axis_p0   <= 2'b00;
      inj_count <= 8'd0;
    end else begin
      anc_p0  <= emit ? syndrome_of(pend_axis, pend_qubit) : 4'b0000;
      axis_p0 <= slot;
      if (emit) inj_count <= inj_count + 8'd1;
    end
  end

  assign tap[0] = {anc_p0, axis_p0};

  for (genvar k = 0; k < OUT_STAGES; k++) begin : g_out
    logic [5:0] stage_q;
    // Output alignment stage k+1: syndrome and its tag move together.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) stage_q <= 6'd0;
      else        stage_q <= tap[k];
    end
    assign tap[k+1] = stage_q;
  end

  assign {ancilla, anc_axis} = tap[OUT_STAGES];

endmodule
